// File: rtl/multicycle_divider.sv
// Iterative restoring radix-2 divider, signed/unsigned, one quotient bit per clock.
// Define DIVIDER_FASTPATH_EN to skip the iteration phase for divide-by-zero and |dividend| < |divisor|.
module multicycle_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic             ovf,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    // state | meaning
    // IDLE  | waiting for start, results held
    // CALC  | one restoring iteration per clock
    // FIX   | apply signs, publish results, pulse done
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state, state_nxt;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] qr;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             qsign, rsign, dbz_pend, ovf_pend;

    logic             dvd_neg, dvs_neg, fast, ge;
    logic [WIDTH-1:0] dvd_abs, dvs_abs, diff;
    logic [WIDTH:0]   trial;

    always_comb begin
        dvd_neg = signed_op & dividend[WIDTH-1];
        dvs_neg = signed_op & divisor[WIDTH-1];
        dvd_abs = dvd_neg ? -dividend : dividend;
        dvs_abs = dvs_neg ? -divisor : divisor;
        // trial is the WIDTH+1 bit partial remainder; the true difference always fits WIDTH bits
        trial   = {acc, qr[WIDTH-1]};
        ge      = trial >= {1'b0, dvs};
        diff    = trial[WIDTH-1:0] - dvs;
    end

`ifdef DIVIDER_FASTPATH_EN
    assign fast = (divisor == '0) || (dvd_abs < dvs_abs);
`else
    assign fast = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = fast ? FIX : CALC;
            CALC:    if (cnt == LAST) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            acc       <= '0;
            qr        <= '0;
            dvs       <= '0;
            cnt       <= '0;
            qsign     <= 1'b0;
            rsign     <= 1'b0;
            dbz_pend  <= 1'b0;
            ovf_pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy     <= 1'b1;
                    dbz      <= 1'b0;
                    ovf      <= 1'b0;
                    cnt      <= '0;
                    dvs      <= dvs_abs;
                    qsign    <= dvd_neg ^ dvs_neg;
                    rsign    <= dvd_neg;
                    dbz_pend <= (divisor == '0);
                    ovf_pend <= signed_op && (dividend == MIN_VAL) && (divisor == '1);
                    // short-cut ops land directly in the final q=0, r=|dividend| form
                    if (fast) begin
                        acc <= dvd_abs;
                        qr  <= '0;
                    end else begin
                        acc <= '0;
                        qr  <= dvd_abs;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    qr  <= {qr[WIDTH-2:0], ge};
                    acc <= ge ? diff : trial[WIDTH-1:0];
                end
                FIX: begin
                    quotient  <= dbz_pend ? '1 : (qsign ? -qr : qr);
                    remainder <= rsign ? -acc : acc;
                    dbz       <= dbz_pend;
                    ovf       <= ovf_pend;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_divider.sv
// Self-checking bench for multicycle_divider (WIDTH=32): directed table, handshake corners, random vs model.
module tb_multicycle_divider;

    localparam int W = 32;
    localparam logic [W-1:0] MIN_VAL = 32'h8000_0000;
`ifdef DIVIDER_FASTPATH_EN
    localparam bit FAST_BUILD = 1'b1;
`else
    localparam bit FAST_BUILD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         signed_op = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, dbz, ovf;
    logic [W-1:0] quotient, remainder;

    int n_checks = 0;
    int n_pass = 0;

    multicycle_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .dbz(dbz), .ovf(ovf), .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        logic         fst;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    // accepted on the next rising edge; operands are scrambled afterwards
    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1;
        signed_op = s;
        dividend = a;
        divisor = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        dividend = $urandom;
        divisor = $urandom;
        signed_op = ~s;
    endtask

    // lat = rising edges from the accepting edge to the one that raises done; -1 on timeout
    task automatic wait_done(input int inject, output int lat, output int busy_n);
        lat = -1;
        busy_n = busy ? 1 : 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_n++;
            if (i == inject) begin
                start = 1'b1;
                signed_op = 1'b0;
                dividend = 32'd50;
                divisor = 32'd5;
            end
            if (i == inject + 1) start = 1'b0;
        end
        start = 1'b0;
    endtask

    function automatic int exp_lat(input logic fst);
        return (FAST_BUILD && fst) ? 1 : W + 1;
    endfunction

    function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz, output logic ov, output logic fst);
        longint sa, sb;
        logic [W:0] ma, mb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = (b == '0);
        ov = s && (a == MIN_VAL) && (b == '1);
        ma = (s && a[W-1]) ? 33'(-sa) : {1'b0, a};
        mb = (s && b[W-1]) ? 33'(-sb) : {1'b0, b};
        fst = dz || (ma < mb);
        if (dz) begin
            q = '1;
            r = a;
        end else if (ov) begin
            q = MIN_VAL;
            r = '0;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endfunction

    initial begin
        int lat, busy_n;
        logic seen;
        logic [W-1:0] eq, er;
        logic edz, eov, efst;

        //          sgn   dividend       divisor        quotient       remainder      dbz   ovf   fast
        vecs[0]  = '{1'b0, 32'd100,      32'd7,         32'd14,        32'd2,         1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'hFFFFFF9C, 32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 32'd100,      32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,         1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'hFFFFFFFF, 32'd2,         32'h7FFFFFFF,  32'd1,         1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'd1234,     32'd0,         32'hFFFFFFFF,  32'd1234,      1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 32'd5,        32'd9,         32'd0,         32'd5,         1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 32'd7,        32'd0,         32'hFFFFFFFF,  32'd7,         1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF,  1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 32'hFFFFFFFB, 32'd0,         32'hFFFFFFFF,  32'hFFFFFFFB,  1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 32'h80000000, 32'd1,         32'h80000000,  32'd0,         1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_dbz", {31'd0, dbz}, 32'd0);
        chk("reset_ovf", {31'd0, ovf}, 32'd0);
        chk("reset_q", quotient, 32'd0);
        chk("reset_r", remainder, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].sgn, vecs[i].a, vecs[i].b);
            wait_done(-5, lat, busy_n);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(exp_lat(vecs[i].fst)));
            chk($sformatf("vec%0d_busy", i), 32'(busy_n), 32'(exp_lat(vecs[i].fst)));
            chk($sformatf("vec%0d_q", i), quotient, vecs[i].q);
            chk($sformatf("vec%0d_r", i), remainder, vecs[i].r);
            chk($sformatf("vec%0d_dbz", i), {31'd0, dbz}, {31'd0, vecs[i].dz});
            chk($sformatf("vec%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ov});
        end

        // start pulsed mid-operation must be dropped, not queued
        issue(1'b0, 32'd1000, 32'd10);
        wait_done(5, lat, busy_n);
        chk("midstart_lat", 32'(lat), 32'(W + 1));
        chk("midstart_q", quotient, 32'd100);
        chk("midstart_r", remainder, 32'd0);
        @(posedge clk);
        #1;
        chk("done_pulse_low", {31'd0, done}, 32'd0);
        chk("midstart_no_queue", {31'd0, busy}, 32'd0);
        chk("q_held", quotient, 32'd100);

        // back-to-back: second start lands in the done cycle
        issue(1'b0, 32'd100, 32'd7);
        wait_done(-5, lat, busy_n);
        chk("b2b_first_q", quotient, 32'd14);
        chk("b2b_done_high", {31'd0, done}, 32'd1);
        issue(1'b1, 32'hFFFFFF9C, 32'd7);
        wait_done(-5, lat, busy_n);
        chk("b2b_second_lat", 32'(lat), 32'(W + 1));
        chk("b2b_second_q", quotient, 32'hFFFFFFF2);
        chk("b2b_second_r", remainder, 32'hFFFFFFFE);

        // reset at cycle 10 of an op after a dbz result
        issue(1'b0, 32'd1234, 32'd0);
        wait_done(-5, lat, busy_n);
        issue(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        chk("rst_mid_dbz", {31'd0, dbz}, 32'd0);
        chk("rst_mid_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_mid_q", quotient, 32'd0);
        chk("rst_mid_r", remainder, 32'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        chk("rst_mid_no_done", {31'd0, seen}, 32'd0);

        for (int n = 0; n < 300; n++) begin
            logic s;
            logic [W-1:0] a, b;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 300));
                2:       b = -32'($urandom_range(1, 300));
                3:       begin a = MIN_VAL; b = '1; end
                4:       begin a = 32'($urandom_range(0, 1000)); b = $urandom; end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            model(s, a, b, eq, er, edz, eov, efst);
            issue(s, a, b);
            wait_done(-5, lat, busy_n);
            chk($sformatf("rand%0d_lat", n), 32'(lat), 32'(exp_lat(efst)));
            chk($sformatf("rand%0d_q", n), quotient, eq);
            chk($sformatf("rand%0d_r", n), remainder, er);
            chk($sformatf("rand%0d_dbz", n), {31'd0, dbz}, {31'd0, edz});
            chk($sformatf("rand%0d_ovf", n), {31'd0, ovf}, {31'd0, eov});
            if (b != '0) chk($sformatf("rand%0d_ident", n), quotient * b + remainder, a);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
